// File: rtl/mips_control_fsm.sv
// mips_control_fsm
// Sequencing controller for the single-cycle MIPS datapath. It holds the
// datapath in reset for a few cycles after power-up and then runs freely or
// one instruction per step pulse. Control lines are decoded from the
// datapath's opcode/func/zero and only reach the datapath during an execute
// cycle. Cycle and retired-instruction counters feed the debug display.
module mips_control_fsm #(
  parameter int RST_CYCLES = 2,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    opcode,
  input  logic [5:0]    func,
  input  logic          zero,
  input  logic          go,
  input  logic          step_mode,
  input  logic          step,
  input  logic          halt_req,
  output logic          regWrite,
  output logic          memRead,
  output logic          memWrite,
  output logic          memToReg,
  output logic          aluSrc,
  output logic          regDst,
  output logic [1:0]    pcSrc,
  output logic [2:0]    aluOp,
  output logic          dp_reset,
  output logic          pc_en,
  output logic [1:0]    state,
  output logic          illegal,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_RST_HOLD  = 2'b00,
    ST_RUN       = 2'b01,
    ST_STEP_WAIT = 2'b10,
    ST_HALT      = 2'b11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  // The hold counter stops on its last value; dp_reset falling marks the end of the hold.
  localparam logic [3:0] HOLD_LAST = 4'(RST_CYCLES - 1);

  state_t      cur_state;
  logic [3:0]  hold_cnt;

  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_mem_to_reg;
  logic        dec_alu_src;
  logic        dec_reg_dst;
  logic [1:0]  dec_pc_src;
  logic [2:0]  dec_alu_op;
  logic        dec_known;
  logic        dec_halt;
  logic        exec;

  assign state = cur_state;

  // An instruction executes every RUN cycle and on a step pulse while waiting; a halt request always wins.
  assign exec = !halt_req &&
                ((cur_state == ST_RUN) || ((cur_state == ST_STEP_WAIT) && step));

  // Raw decode of the instruction presented by the datapath, independent of sequencing.
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_pc_src     = PC_SEQ;
    dec_alu_op     = ALU_AND;
    dec_known      = 1'b1;
    dec_halt       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            dec_reg_dst    = 1'b1;
            dec_reg_write  = 1'b1;
            dec_mem_to_reg = 1'b1;
            case (func)
              FN_ADD:  dec_alu_op = ALU_ADD;
              FN_SUB:  dec_alu_op = ALU_SUB;
              FN_AND:  dec_alu_op = ALU_AND;
              FN_OR:   dec_alu_op = ALU_OR;
              default: dec_alu_op = ALU_SLT;
            endcase
          end
          FN_JR:   dec_pc_src = PC_REG;
          default: dec_known  = 1'b0;
        endcase
      end
      OP_LW: begin
        dec_alu_src   = 1'b1;
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_op    = ALU_ADD;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        dec_alu_op = ALU_SUB;
        dec_pc_src = zero ? PC_BRANCH : PC_SEQ;
      end
      OP_ADDI: begin
        dec_alu_src    = 1'b1;
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_alu_op     = ALU_ADD;
      end
      OP_J:    dec_pc_src = PC_JUMP;
      OP_HALT: dec_halt   = 1'b1;
      default: dec_known  = 1'b0;
    endcase
  end

  // Gate the decode onto the datapath; nothing moves outside an execute cycle and halt freezes the PC.
  always_comb begin
    regWrite = exec & dec_reg_write;
    memRead  = exec & dec_mem_read;
    memWrite = exec & dec_mem_write;
    memToReg = exec & dec_mem_to_reg;
    aluSrc   = exec & dec_alu_src;
    regDst   = exec & dec_reg_dst;
    pcSrc    = exec ? dec_pc_src : PC_SEQ;
    aluOp    = exec ? dec_alu_op : ALU_AND;
    pc_en    = exec & ~dec_halt;
  end

  // Sequencing state, datapath reset hold, sticky illegal flag and debug counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state   <= ST_RST_HOLD;
      hold_cnt    <= 4'd0;
      dp_reset    <= 1'b1;
      illegal     <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (exec) begin
        instr_count <= instr_count + CW'(1);
        if (cur_state == ST_RUN) begin
          cycle_count <= cycle_count + CW'(1);
        end
        if (!dec_known) begin
          illegal <= 1'b1;
        end
      end
      case (cur_state)
        ST_RST_HOLD: begin
          if (dp_reset) begin
            if (hold_cnt == HOLD_LAST) begin
              dp_reset <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 4'd1;
            end
          end else if (go) begin
            cur_state <= step_mode ? ST_STEP_WAIT : ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt_req || dec_halt) begin
            cur_state <= ST_HALT;
          end else if (step_mode) begin
            cur_state <= ST_STEP_WAIT;
          end
        end
        ST_STEP_WAIT: begin
          if (halt_req || (step && dec_halt)) begin
            cur_state <= ST_HALT;
          end else if (!step_mode && go) begin
            cur_state <= ST_RUN;
          end
        end
        ST_HALT: begin
          if (go && !halt_req) begin
            cur_state <= step_mode ? ST_STEP_WAIT : ST_RUN;
          end
        end
        default: cur_state <= ST_RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// tb_mips_control_fsm
// Directed and random stimulus for the MIPS sequencing controller, checked
// against a behavioural model built from the instruction table and the
// run/step/halt rules. Counters are modelled as plain integers modulo 2^CW.
module tb_mips_control_fsm;

  localparam int RST_CYCLES = 2;
  localparam int CW         = 8;
  localparam int MOD        = 1 << CW;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_JR    = 6'b001000;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic [5:0]    func;
  logic          zero;
  logic          go;
  logic          step_mode;
  logic          step;
  logic          halt_req;
  logic          regWrite;
  logic          memRead;
  logic          memWrite;
  logic          memToReg;
  logic          aluSrc;
  logic          regDst;
  logic [1:0]    pcSrc;
  logic [2:0]    aluOp;
  logic          dp_reset;
  logic          pc_en;
  logic [1:0]    state;
  logic          illegal;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instr_count;

  always #5 clk = ~clk;

  mips_control_fsm #(.RST_CYCLES(RST_CYCLES), .CW(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .go(go), .step_mode(step_mode), .step(step), .halt_req(halt_req),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .aluSrc(aluSrc), .regDst(regDst), .pcSrc(pcSrc),
    .aluOp(aluOp), .dp_reset(dp_reset), .pc_en(pc_en), .state(state),
    .illegal(illegal), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       known;
    logic       halt;
  } dec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int pc_en_seen = 0;
  int dp_reset_seen = 0;

  // Model: mode 0 reset hold, 1 run, 2 step wait, 3 halt.
  int m_state;
  int m_held;
  bit m_ill;
  int m_cyc;
  int m_ins;

  function automatic dec_t ref_decode(input logic [5:0] op, input logic [5:0] fn, input logic z);
    dec_t d;
    d = '0;
    d.known = 1'b1;
    if (op == OP_R) begin
      if (fn == F_JR) d.pc_src = 2'd2;
      else if (fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR || fn == F_SLT) begin
        d.reg_dst = 1'b1; d.reg_write = 1'b1; d.mem_to_reg = 1'b1;
        d.alu_op = (fn == F_ADD) ? 3'b010 : (fn == F_SUB) ? 3'b110 :
                   (fn == F_AND) ? 3'b000 : (fn == F_OR) ? 3'b001 : 3'b111;
      end else d.known = 1'b0;
    end else if (op == OP_LW) begin
      d.alu_src = 1'b1; d.mem_read = 1'b1; d.reg_write = 1'b1; d.alu_op = 3'b010;
    end else if (op == OP_SW) begin
      d.alu_src = 1'b1; d.mem_write = 1'b1; d.alu_op = 3'b010;
    end else if (op == OP_BEQ) begin
      d.alu_op = 3'b110; d.pc_src = z ? 2'd1 : 2'd0;
    end else if (op == OP_ADDI) begin
      d.alu_src = 1'b1; d.reg_write = 1'b1; d.mem_to_reg = 1'b1; d.alu_op = 3'b010;
    end else if (op == OP_J) d.pc_src = 2'd3;
    else if (op == OP_HALT) d.halt = 1'b1;
    else d.known = 1'b0;
    return d;
  endfunction

  task automatic model_reset();
    m_state = 0; m_held = 0; m_ill = 0; m_cyc = 0; m_ins = 0;
  endtask

  function automatic bit model_exec();
    return !halt_req && (m_state == 1 || (m_state == 2 && step));
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_clock();
    dec_t d;
    bit   ex;
    d  = ref_decode(opcode, func, zero);
    ex = model_exec();
    if (ex) begin
      if (m_state == 1) m_cyc = (m_cyc + 1) % MOD;
      m_ins = (m_ins + 1) % MOD;
      if (!d.known) m_ill = 1;
    end
    if (m_state == 0) begin
      if (m_held < RST_CYCLES) m_held++;
      else if (go) m_state = step_mode ? 2 : 1;
    end else if (m_state == 1) begin
      if (halt_req || d.halt) m_state = 3;
      else if (step_mode) m_state = 2;
    end else if (m_state == 2) begin
      if (halt_req || (step && d.halt)) m_state = 3;
      else if (!step_mode && go) m_state = 1;
    end else begin
      if (go && !halt_req) m_state = step_mode ? 2 : 1;
    end
  endtask

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model for the inputs now applied.
  task automatic check_output(input string tag);
    dec_t d;
    bit   ex;
    d  = ref_decode(opcode, func, zero);
    ex = model_exec();
    check_value({tag, ".state"},    32'(state),       32'(m_state));
    check_value({tag, ".dp_reset"}, 32'(dp_reset),    32'(m_state == 0 && m_held < RST_CYCLES));
    check_value({tag, ".illegal"},  32'(illegal),     32'(m_ill));
    check_value({tag, ".cycles"},   32'(cycle_count), 32'(m_cyc));
    check_value({tag, ".instrs"},   32'(instr_count), 32'(m_ins));
    check_value({tag, ".pc_en"},    32'(pc_en),       32'(ex && !d.halt));
    check_value({tag, ".regWrite"}, 32'(regWrite),    32'(ex && d.reg_write));
    check_value({tag, ".memRead"},  32'(memRead),     32'(ex && d.mem_read));
    check_value({tag, ".memWrite"}, 32'(memWrite),    32'(ex && d.mem_write));
    check_value({tag, ".pcSrc"},    32'(pcSrc),       ex ? 32'(d.pc_src) : 32'd0);
    if (ex) begin
      check_value({tag, ".memToReg"}, 32'(memToReg), 32'(d.mem_to_reg));
      check_value({tag, ".aluSrc"},   32'(aluSrc),   32'(d.alu_src));
      check_value({tag, ".regDst"},   32'(regDst),   32'(d.reg_dst));
      check_value({tag, ".aluOp"},    32'(aluOp),    32'(d.alu_op));
    end
    if (!reset) begin
      check_value({tag, ".rst_ctl"}, 32'({memToReg, aluSrc, regDst, aluOp}), 32'd0);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check, then let the rising edge happen.
  task automatic apply_stimulus(input bit g, input bit sm, input bit st, input bit hr,
                                input logic [5:0] op, input logic [5:0] fn, input bit z,
                                input string tag);
    go = g; step_mode = sm; step = st; halt_req = hr;
    opcode = op; func = fn; zero = z;
    #1;
    if (!reset) model_reset();
    check_output(tag);
    if (pc_en === 1'b1) pc_en_seen++;
    if (dp_reset === 1'b1) dp_reset_seen++;
    @(posedge clk);
    if (reset) model_clock();
    @(negedge clk);
  endtask

  initial begin
    int snap_ins;
    int snap_cyc;
    bit sm;
    int r;
    logic [5:0] legal_op [11];
    logic [5:0] legal_fn [11];
    legal_op = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    legal_fn = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_JR, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

    reset = 1'b0; go = 1'b0; step_mode = 1'b0; step = 1'b0; halt_req = 1'b0;
    opcode = OP_R; func = F_ADD; zero = 1'b0;
    model_reset();
    @(negedge clk);
    apply_stimulus(1, 0, 1, 0, OP_R, F_ADD, 0, "in_reset_a");
    apply_stimulus(1, 0, 1, 0, OP_LW, 6'd0, 0, "in_reset_b");

    // Reset release: dp_reset must stay high for exactly RST_CYCLES cycles.
    reset = 1'b1;
    dp_reset_seen = 0;
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 0, OP_R, F_ADD, 0, "hold");
    check_value("dp_reset_cycles", 32'(dp_reset_seen), 32'(RST_CYCLES));
    apply_stimulus(1, 0, 0, 0, OP_R, F_ADD, 0, "go_run");
    check_value("run_entered", 32'(state), 32'd1);

    // Directed instructions in RUN.
    apply_stimulus(1, 0, 0, 0, OP_R,    F_SUB, 0, "sub");
    apply_stimulus(1, 0, 0, 0, OP_BEQ,  6'd0,  1, "beq_taken");
    apply_stimulus(1, 0, 0, 0, OP_BEQ,  6'd0,  0, "beq_not_taken");
    apply_stimulus(1, 0, 0, 0, OP_LW,   6'd7,  0, "lw");
    apply_stimulus(1, 0, 0, 0, OP_SW,   6'd9,  1, "sw");
    apply_stimulus(1, 0, 0, 0, OP_ADDI, 6'd3,  0, "addi");
    apply_stimulus(1, 0, 0, 0, OP_J,    6'd0,  0, "j");
    apply_stimulus(1, 0, 0, 0, OP_R,    F_JR,  0, "jr");
    apply_stimulus(1, 0, 0, 0, OP_R,    F_SLT, 0, "slt");

    // Single-step: three pulses separated by idle cycles.
    apply_stimulus(1, 1, 0, 0, OP_R, F_OR, 0, "enter_step");
    snap_ins = m_ins; snap_cyc = m_cyc; pc_en_seen = 0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1, 1, 0, OP_ADDI, 6'd0, 0, "step_pulse");
      apply_stimulus(0, 1, 0, 0, OP_ADDI, 6'd0, 0, "step_idle_a");
      apply_stimulus(1, 1, 0, 0, OP_LW,   6'd0, 0, "step_idle_b");
    end
    check_value("step_retired", 32'(instr_count), 32'((snap_ins + 3) % MOD));
    check_value("step_cycles",  32'(cycle_count), 32'(snap_cyc));
    check_value("step_pc_en",   32'(pc_en_seen),  32'd3);

    // Halt request beats a simultaneous step.
    snap_ins = m_ins;
    apply_stimulus(0, 1, 1, 1, OP_R, F_ADD, 0, "halt_with_step");
    check_value("halt_state",      32'(state),       32'd3);
    check_value("halt_no_retire",  32'(instr_count), 32'(snap_ins));
    apply_stimulus(0, 0, 0, 0, OP_R, F_ADD, 0, "halted_idle");
    apply_stimulus(1, 0, 0, 0, OP_R, F_ADD, 0, "resume");

    // Halt instruction retires and stops.
    snap_ins = m_ins;
    apply_stimulus(1, 0, 0, 0, OP_HALT, 6'd0, 0, "halt_op");
    check_value("halt_op_state",  32'(state),       32'd3);
    check_value("halt_op_retire", 32'(instr_count), 32'((snap_ins + 1) % MOD));
    apply_stimulus(1, 0, 0, 0, OP_R, F_ADD, 0, "resume2");
    check_value("resume2_state", 32'(state), 32'd1);

    // Illegal instruction is sticky across valid ones.
    apply_stimulus(1, 0, 0, 0, 6'b010101, 6'd0, 0, "illegal_op");
    check_value("illegal_set", 32'(illegal), 32'd1);
    apply_stimulus(1, 0, 0, 0, OP_R,   F_AND, 0, "after_ill_a");
    apply_stimulus(1, 0, 0, 0, OP_BEQ, 6'd0,  1, "after_ill_b");
    check_value("illegal_held", 32'(illegal), 32'd1);

    // Asynchronous reset between clock edges while running.
    go = 1'b1; step_mode = 1'b0; step = 1'b0; halt_req = 1'b0;
    opcode = OP_LW; func = 6'd0; zero = 1'b0;
    #1;
    check_output("pre_async");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_output("async_reset");
    check_value("async_state", 32'(state),    32'd0);
    check_value("async_dprst", 32'(dp_reset), 32'd1);
    @(negedge clk);
    apply_stimulus(1, 0, 0, 0, OP_R, F_ADD, 0, "held_reset");
    reset = 1'b1;

    // Random traffic; CW is small so both counters wrap during this phase.
    sm = 1'b0;
    for (int i = 0; i < 900; i++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int k;
      if ($urandom_range(0, 19) == 0) sm = ~sm;
      r = int'($urandom_range(0, 99));
      k = int'($urandom_range(0, 10));
      op = legal_op[k];
      fn = (op == OP_R) ? legal_fn[k] : 6'($urandom);
      if (r < 2) op = OP_HALT;
      else if (r < 3) begin op = 6'b010101; fn = 6'($urandom); end
      else if (r < 4) begin op = OP_R; fn = 6'b111000; end
      apply_stimulus($urandom_range(0, 7) != 0, sm, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 39) == 0, op, fn, 1'($urandom), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_control_fsm.md
Name: mips_control_fsm

Overview:
- Sequencing controller upstream of the single-cycle MIPS datapath.
- Consumes the datapath's opcode, func and zero.
- Drives every datapath control input, plus a datapath reset, a PC enable and run/step/halt sequencing.
- Keeps cycle and retired-instruction counters for the debug display path.

Parameters:
RST_CYCLES, 2, number of cycles dp_reset is held high after reset release (1..15)
CW, 16, width of cycle_count and instr_count

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  6  instruction bits [31:26] from datapath
func  input  6  instruction bits [5:0] from datapath
zero  input  1  ALU zero flag from datapath
go  input  1  level; starts/resumes execution from RUN-capable states
step_mode  input  1  1 = single-step operation
step  input  1  single-cycle pulse; executes one instruction in step mode
halt_req  input  1  external halt request
regWrite, memRead, memWrite, memToReg, aluSrc, regDst  output  1 each  datapath controls
pcSrc  output  2  0=PC+4, 1=branch, 2=register (jr), 3=jump
aluOp  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
dp_reset  output  1  active-high reset to datapath program counter
pc_en  output  1  program counter update enable
state  output  2  00 RST_HOLD, 01 RUN, 10 STEP_WAIT, 11 HALT
illegal  output  1  sticky, unknown opcode/func executed
cycle_count  output  CW  cycles spent in RUN
instr_count  output  CW  instructions retired

Behaviour:
- Reset asserted: state=RST_HOLD, hold counter=0, dp_reset=1, pc_en=0, all strobes/selects 0, pcSrc=0, aluOp=000, illegal=0, counters=0.
- RST_HOLD: dp_reset=1 until the hold counter reaches RST_CYCLES-1, then dp_reset=0 and the FSM waits for go=1.
  - go=1 and step_mode=0 -> RUN.
  - go=1 and step_mode=1 -> STEP_WAIT.
- Execute cycle: every RUN cycle, and a STEP_WAIT cycle with step=1.
  - Decode outputs are combinational from opcode/func/zero; pc_en=1.
  - On the clock edge, instr_count increments, and cycle_count increments when in RUN.
  - Outside an execute cycle: regWrite, memWrite, memRead=0, pc_en=0, pcSrc=0.
- Decode table (all unlisted outputs 0):
  - opcode 000000, func 100000 -> regDst=1, regWrite=1, memToReg=1, aluOp=010.
  - opcode 000000, func 100010 -> regDst=1, regWrite=1, memToReg=1, aluOp=110.
  - opcode 000000, func 100100 -> regDst=1, regWrite=1, memToReg=1, aluOp=000.
  - opcode 000000, func 100101 -> regDst=1, regWrite=1, memToReg=1, aluOp=001.
  - opcode 000000, func 101010 -> regDst=1, regWrite=1, memToReg=1, aluOp=111.
  - opcode 000000, func 001000 (jr) -> pcSrc=2.
  - 100011 lw -> aluSrc=1, memRead=1, regWrite=1, memToReg=0, aluOp=010.
  - 101011 sw -> aluSrc=1, memWrite=1, aluOp=010.
  - 000100 beq -> aluOp=110, pcSrc = zero ? 1 : 0.
  - 001000 addi -> aluSrc=1, regWrite=1, memToReg=1, aluOp=010.
  - 000010 j -> pcSrc=3.
  - 111111 halt -> no strobes, pc_en=0; the instruction is retired and the FSM goes to HALT.
  - Anything else -> treated as NOP (pc_en=1, retired), illegal set (sticky until reset).
- RUN transitions:
  - halt_req=1 -> HALT. Takes priority; that cycle is not an execute cycle: strobes 0, pc_en=0, not retired.
  - step_mode=1 -> STEP_WAIT at the next edge; the current cycle still executes.
- STEP_WAIT transitions:
  - halt_req=1 -> HALT; a concurrent step is ignored.
  - step_mode=0 and go=1 -> RUN.
- HALT: outputs gated, counters frozen, dp_reset=0. go=1 with halt_req=0 -> RUN, or STEP_WAIT if step_mode=1. Resumption is at the PC held in the datapath.
- Counters wrap modulo 2^CW without saturation.
- Reset asserted mid-operation: immediate asynchronous return to RST_HOLD and all reset values.

Test Plan:
- Reset release with RST_CYCLES=2 -> dp_reset=1 for exactly 2 cycles, state=00; then go=1 -> state=01, pc_en=1.
- opcode=000000, func=100010 in RUN -> regDst=1, regWrite=1, memToReg=1, aluOp=110, pcSrc=0.
- beq (000100) with zero=1 -> pcSrc=1; with zero=0 -> pcSrc=0; regWrite=0.
- step_mode=1, three step pulses spaced by idle cycles -> instr_count +3, pc_en high exactly 3 cycles, cycle_count unchanged; halt_req with step in the same cycle -> HALT, no retire.
- halt opcode 111111 in RUN -> next state=11, instr_count+1, all strobes 0; go=1 -> state=01.
- opcode 010101 -> illegal=1, held through later valid instructions; async reset mid-RUN -> all outputs at reset values before the next clock edge.
